// File: rtl/link_piso_serializer_if.sv
// Handshake bundle for link_piso_serializer.
// Wide-word input side uses ready/valid. Slice output side uses valid/yumi.
// Signal names keep the _i/_o suffixes as seen from the serializer.
interface link_piso_serializer_if #(
  parameter int width_p = 8,
  parameter int els_p   = 4
);
  logic                       valid_i;
  logic [els_p*width_p-1:0]   data_i;
  logic                       ready_and_o;
  logic                       valid_o;
  logic [width_p-1:0]         data_o;
  logic                       yumi_i;

  // Serializer side.
  modport slave (
    input  valid_i, data_i, yumi_i,
    output ready_and_o, valid_o, data_o
  );

  // Word producer / slice consumer side.
  modport master (
    output valid_i, data_i, yumi_i,
    input  ready_and_o, valid_o, data_o
  );
endinterface

// File: rtl/link_piso_serializer.sv
// link_piso_serializer: parallel-in/serial-out converter for the link upstream path.
// Captures one els_p*width_p word on a ready/valid handshake and emits it as
// els_p width_p-bit slices on a valid/yumi handshake. A new word can be taken in
// the same cycle the last slice is consumed, so back-to-back words leave no bubble.
// Optional macro LINK_PISO_CHECK_EN compiles in simulation-only protocol checks.
module link_piso_serializer #(
  parameter int width_p    = 8,
  parameter int els_p      = 4,
  parameter int hi_to_lo_p = 0
) (
  input logic                   clk_i,
  input logic                   reset_i,
  link_piso_serializer_if.slave link
);

  localparam int cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(els_p - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                          state_r, state_n;
  logic [cnt_w_lp-1:0]             cnt_r, cnt_n;
  logic [els_p-1:0][width_p-1:0]   data_r;

  logic busy_r;
  logic last;
  logic ready;
  logic accept;
  logic consume;

  assign busy_r  = (state_r == ST_BUSY);
  // With els_p=1 cnt_r never leaves 0, so last is constantly 1.
  assign last    = (cnt_r == cnt_last_lp);
  // yumi_i while idle is illegal and must not disturb state, hence the busy_r gate.
  assign consume = busy_r & link.yumi_i;
  // Combinational yumi_i -> ready path lets the next word refill as the last slice leaves.
  assign ready   = ~busy_r | (last & link.yumi_i);
  assign accept  = link.valid_i & ready;

  assign link.ready_and_o = ready;
  assign link.valid_o     = busy_r;

  // Slice select: slice order depends on hi_to_lo_p.
  if (els_p == 1) begin : g_single
    assign link.data_o = data_r[0];
  end else begin : g_multi
    logic [cnt_w_lp-1:0] sel;
    assign sel         = (hi_to_lo_p != 0) ? (cnt_last_lp - cnt_r) : cnt_r;
    assign link.data_o = data_r[sel];
  end

  // Next-state: advance on consume, wrap on last, accept overrides with a fresh word.
  // NOTE: every output of a combinational block gets a default first; any path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (consume) begin
      if (last) begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n   = cnt_r + 1'b1;
      end
    end
    if (accept) begin
      state_n = ST_BUSY;
      cnt_n   = '0;
    end
  end

  // State register: synchronous reset discards any partially sent word.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Word capture on an accepting cycle.
  // NOTE: the data holding register is deliberately not reset; it is only read while
  // busy, and busy is only set by a capture, so reset adds fanout for no benefit.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_r <= link.data_i;
    end
  end

`ifdef LINK_PISO_CHECK_EN
  if (width_p < 1 || els_p < 1) begin : g_param_err
    $error("link_piso_serializer: width_p and els_p must both be >= 1");
  end

  // Protocol and counter-range checks, suppressed while reset is applied.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (link.yumi_i && !link.valid_o) begin
        $error("link_piso_serializer: yumi_i asserted while valid_o is low");
      end
      if (int'(cnt_r) >= els_p) begin
        $error("link_piso_serializer: slice counter out of range (%0d)", cnt_r);
      end
    end
  end
`endif

endmodule

// File: tb/tb_link_piso_serializer.sv
// Bench for link_piso_serializer. Three instances run side by side:
//   dut0: width 4, 3 slices, low slice first
//   dut1: width 4, 3 slices, high slice first
//   dut2: width 8, 1 slice (single-entry pipeline register)
// A queue-based model holds, per instance, the slices still owed to the consumer.
module tb_link_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  logic rst_req;

  logic        drv_valid [3];
  logic        drv_yumi  [3];
  logic [11:0] drv_data  [3];
  logic        obs_valid [3];
  logic        obs_ready [3];
  logic [7:0]  obs_data  [3];

  int   mode   [3];   // 0 no yumi, 1 yumi whenever owed, 2 random legal, 3 random incl. illegal
  logic took_r [3];

  logic [11:0] src_q   [3][$];
  logic [7:0]  exp_q   [3][$];
  logic [7:0]  out_log [3][$];
  logic        rdy_log [$];
  int          cyc_log [$];
  int          cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  bit mv, mr, consume_m, take_m;

  always #5 clk = ~clk;

  link_piso_serializer_if #(.width_p(4), .els_p(3)) if0 ();
  link_piso_serializer_if #(.width_p(4), .els_p(3)) if1 ();
  link_piso_serializer_if #(.width_p(8), .els_p(1)) if2 ();

  assign if0.valid_i = drv_valid[0];
  assign if0.data_i  = drv_data[0];
  assign if0.yumi_i  = drv_yumi[0];
  assign if1.valid_i = drv_valid[1];
  assign if1.data_i  = drv_data[1];
  assign if1.yumi_i  = drv_yumi[1];
  assign if2.valid_i = drv_valid[2];
  assign if2.data_i  = drv_data[2][7:0];
  assign if2.yumi_i  = drv_yumi[2];

  assign obs_valid[0] = if0.valid_o;
  assign obs_ready[0] = if0.ready_and_o;
  assign obs_data[0]  = {4'h0, if0.data_o};
  assign obs_valid[1] = if1.valid_o;
  assign obs_ready[1] = if1.ready_and_o;
  assign obs_data[1]  = {4'h0, if1.data_o};
  assign obs_valid[2] = if2.valid_o;
  assign obs_ready[2] = if2.ready_and_o;
  assign obs_data[2]  = if2.data_o;

  link_piso_serializer #(.width_p(4), .els_p(3), .hi_to_lo_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .link(if0.slave));
  link_piso_serializer #(.width_p(4), .els_p(3), .hi_to_lo_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .link(if1.slave));
  link_piso_serializer #(.width_p(8), .els_p(1), .hi_to_lo_p(0)) dut2 (
    .clk_i(clk), .reset_i(rst), .link(if2.slave));

  function automatic int els_of(input int id);
    return (id == 2) ? 1 : 3;
  endfunction

  function automatic int w_of(input int id);
    return (id == 2) ? 8 : 4;
  endfunction

  function automatic bit hl_of(input int id);
    return (id == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: compares outputs, then advances to the state after the next edge.
  always @(negedge clk) begin
    cyc++;
    for (int id = 0; id < 3; id++) begin
      mv = (exp_q[id].size() != 0);
      mr = !mv || (exp_q[id].size() == 1 && drv_yumi[id]);
      check($sformatf("dut%0d valid_o", id), obs_valid[id], mv);
      check($sformatf("dut%0d ready_and_o", id), obs_ready[id], mr);
      if (mv) check($sformatf("dut%0d data_o", id), obs_data[id], exp_q[id][0]);
      consume_m = !rst && drv_yumi[id] && mv;
      take_m    = !rst && drv_valid[id] && mr;
      if (consume_m) begin
        out_log[id].push_back(obs_data[id]);
        if (id == 0) begin
          rdy_log.push_back(obs_ready[0]);
          cyc_log.push_back(cyc);
        end
      end
      took_r[id] = take_m;
      if (rst) begin
        exp_q[id].delete();
      end else begin
        if (consume_m) void'(exp_q[id].pop_front());
        if (take_m) begin
          for (int k = 0; k < els_of(id); k++) begin
            int idx;
            int sl;
            idx = hl_of(id) ? (els_of(id) - 1 - k) : k;
            sl  = (int'(drv_data[id]) >> (idx * w_of(id))) & ((1 << w_of(id)) - 1);
            exp_q[id].push_back(8'(sl));
          end
        end
      end
    end
  end

  function automatic void drive();
    rst = rst_req;
    for (int id = 0; id < 3; id++) begin
      drv_valid[id] = (src_q[id].size() != 0);
      drv_data[id]  = (src_q[id].size() != 0) ? src_q[id][0] : 12'($urandom);
      case (mode[id])
        1:       drv_yumi[id] = (exp_q[id].size() != 0);
        2:       drv_yumi[id] = (exp_q[id].size() != 0) && ($urandom_range(1) == 1);
        3:       drv_yumi[id] = ($urandom_range(7) == 0) ||
                                ((exp_q[id].size() != 0) && ($urandom_range(1) == 1));
        default: drv_yumi[id] = 1'b0;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      if (took_r[id]) void'(src_q[id].pop_front());
    end
    drive();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int id, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      settle();
      if (out_log[id].size() >= n) break;
    end
  endtask

  task automatic check_log(input string tag, input int id, input logic [7:0] e [6], input int n);
    check({tag, " count"}, out_log[id].size(), n);
    for (int i = 0; i < n && i < out_log[id].size(); i++)
      check($sformatf("%s slice%0d", tag, i), out_log[id][i], e[i]);
  endtask

  task automatic clear_logs();
    for (int id = 0; id < 3; id++) out_log[id].delete();
    rdy_log.delete();
    cyc_log.delete();
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      mode[id]   = 3;
      took_r[id] = 1'b0;
      src_q[id].push_back(12'hFFF);
    end
    rst_req = 1'b1;
    drive();

    // Reset held two cycles with valid_i and yumi_i high: nothing captured.
    step();
    step();
    rst_req = 1'b0;
    for (int id = 0; id < 3; id++) begin
      src_q[id].delete();
      mode[id] = 0;
    end
    drive();
    settle();
    for (int id = 0; id < 3; id++) begin
      check($sformatf("rst dut%0d valid_o", id), obs_valid[id], 1'b0);
      check($sformatf("rst dut%0d ready_and_o", id), obs_ready[id], 1'b1);
    end
    step();
    settle();
    check("post-rst dut0 idle", obs_valid[0], 1'b0);

    // Basic and reversed order on the same word.
    clear_logs();
    src_q[0].push_back(12'hABC);
    src_q[1].push_back(12'hABC);
    mode[0] = 1;
    mode[1] = 1;
    run_until(0, 3, 20);
    check_log("lo_first", 0, '{8'hC, 8'hB, 8'hA, 8'h0, 8'h0, 8'h0}, 3);
    check_log("hi_first", 1, '{8'hA, 8'hB, 8'hC, 8'h0, 8'h0, 8'h0}, 3);
    check("ready pattern", {29'd0, rdy_log.size() == 3 ? {rdy_log[0], rdy_log[1], rdy_log[2]} : 3'b111},
          32'b001);

    // Back-to-back words with valid held: six slices, no bubble.
    step();
    settle();
    clear_logs();
    src_q[0].push_back(12'h123);
    src_q[0].push_back(12'h456);
    run_until(0, 6, 30);
    check_log("b2b", 0, '{8'h3, 8'h2, 8'h1, 8'h6, 8'h5, 8'h4}, 6);
    check("b2b span", (cyc_log.size() == 6) ? cyc_log[5] - cyc_log[0] : -1, 5);

    // Backpressure mid-word.
    step();
    settle();
    clear_logs();
    src_q[0].push_back(12'hABC);
    run_until(0, 1, 20);
    mode[0] = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      settle();
      check("bp valid_o", obs_valid[0], 1'b1);
      check("bp data_o", obs_data[0], 8'hB);
      check("bp ready_and_o", obs_ready[0], 1'b0);
    end
    mode[0] = 1;
    run_until(0, 3, 20);
    check_log("bp", 0, '{8'hC, 8'hB, 8'hA, 8'h0, 8'h0, 8'h0}, 3);
    step();
    settle();
    check("bp done ready", obs_ready[0], 1'b1);
    check("bp done valid", obs_valid[0], 1'b0);
    mode[1] = 0;

    // Single-slice instance with random yumi_i.
    clear_logs();
    mode[2] = 2;
    src_q[2].push_back(12'h011);
    src_q[2].push_back(12'h022);
    src_q[2].push_back(12'h033);
    run_until(2, 3, 200);
    check_log("els1", 2, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0}, 3);

    // Mid-stream reset on the single-slice instance.
    clear_logs();
    src_q[2].push_back(12'h044);
    src_q[2].push_back(12'h055);
    src_q[2].push_back(12'h066);
    run_until(2, 1, 200);
    check("els1 first after refill", (out_log[2].size() != 0) ? out_log[2][0] : 8'h00, 8'h44);
    rst_req = 1'b1;
    step();
    settle();
    rst_req = 1'b0;
    src_q[2].delete();
    mode[2] = 0;
    step();
    settle();
    check("mid rst valid_o", obs_valid[2], 1'b0);
    check("mid rst ready_and_o", obs_ready[2], 1'b1);

    // Random traffic on all instances, illegal yumi_i included.
    for (int id = 0; id < 3; id++) mode[id] = 3;
    for (int c = 0; c < 800; c++) begin
      for (int id = 0; id < 3; id++) begin
        if (src_q[id].size() < 2 && $urandom_range(2) == 0)
          src_q[id].push_back(12'($urandom));
      end
      step();
      settle();
    end
    for (int id = 0; id < 3; id++) mode[id] = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      settle();
    end
    for (int id = 0; id < 3; id++)
      check($sformatf("drain dut%0d", id), obs_valid[id], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
